chain_score_pipe: RTL and testbench



---
 rtl/chain_score_pipe_pkg.sv | 56 +++++
 rtl/chain_score_pipe_ilog2.sv | 26 ++
 rtl/chain_score_pipe.sv | 185 ++++++++++++++++++
 tb/tb_chain_score_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/chain_score_pipe_pkg.sv
// chain_pkg: shared widths, types and stage-register layouts for the
// chain_score_pipe anchor-chaining score pipeline.
//   DEF_COORD_W / DEF_SCORE_W / DEF_IDX_W : default datapath widths
//   coord_t / score_t / idx_t            : coordinate, signed score, index
//   NO_PRED                              : "no predecessor" index marker
//   s1_t / s2_t / s3_t                   : pipeline stage payloads
package chain_pkg;

   localparam int DEF_COORD_W = 32;
   localparam int DEF_SCORE_W = 32;
   localparam int DEF_IDX_W   = 16;

   // log2 of a coordinate needs $clog2(COORD_W) bits; after >>1 one less.
   localparam int LOG_W = $clog2(DEF_COORD_W);
   localparam int LG_W  = LOG_W - 1;

   typedef logic        [DEF_COORD_W-1:0] coord_t;
   typedef logic signed [DEF_SCORE_W-1:0] score_t;
   typedef logic        [DEF_IDX_W-1:0]   idx_t;

   localparam idx_t NO_PRED = '1;

   // Stage 1: raw differences plus everything carried to the accumulator.
   typedef struct packed {
      coord_t dr;
      coord_t dq;
      score_t f_j;
      idx_t   j_idx;
      coord_t w;
      logic   last;
      logic   legal;
   } s1_t;

   // Stage 2: overlap term and the pieces of the gap cost.
   typedef struct packed {
      coord_t          a;
      logic            g_zero;
      score_t          mult;
      logic [LG_W-1:0] lg;
      score_t          f_j;
      idx_t            j_idx;
      coord_t          w;
      logic            last;
      logic            legal;
   } s2_t;

   // Stage 3: finished candidate score ready for the running maximum.
   typedef struct packed {
      score_t cand;
      idx_t   j_idx;
      coord_t w;
      logic   last;
      logic   legal;
   } s3_t;

endpackage

// File: rtl/chain_score_pipe_ilog2.sv
// ilog2: combinational floor(log2(v)).
//   v     in  W        operand
//   log2  out LOG_W    index of the highest set bit (0 when v==0)
//   valid out 1        v is non-zero, so log2 is meaningful
module ilog2 #(
   parameter int W     = 32,
   parameter int LOG_W = $clog2(W)
) (
   input  logic [W-1:0]     v,
   output logic [LOG_W-1:0] log2,
   output logic             valid
);

   // Ascending scan: the last set bit seen is the most significant one.
   always_comb begin
      log2 = '0;
      for (int i = 0; i < W; i++) begin
         if (v[i]) begin
            log2 = LOG_W'(i);
         end
      end
   end

   assign valid = |v;

endmodule

// File: rtl/chain_score_pipe.sv
// chain_score_pipe: streaming (anchor i, predecessor j) pair scorer with a
// per-group running maximum. Emits f_i, best_j and n_eval per anchor group.
//   clk, rst (sync, active high)
//   in_valid/in_ready/in_last, pred_valid, riX/qiX (anchor), riY/qiY (pred),
//   f_j, j_idx, W (anchor span), gap_scale (Qx.FRAC_BITS, static)
//   out_valid/out_ready, f_i, best_j, n_eval
// Pipeline: S1 register at accept, S2, S3, then accumulator/output register,
// so a last beat accepted at edge k shows out_valid after edge k+3.
module chain_score_pipe
   import chain_pkg::*;
#(
   parameter int COORD_W   = DEF_COORD_W,
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int FRAC_BITS = 8,
   parameter int MAX_DIST  = 5000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic               pred_valid,
   input  logic [COORD_W-1:0] riX,
   input  logic [COORD_W-1:0] qiX,
   input  logic [COORD_W-1:0] riY,
   input  logic [COORD_W-1:0] qiY,
   input  logic [SCORE_W-1:0] f_j,
   input  logic [IDX_W-1:0]   j_idx,
   input  logic [COORD_W-1:0] W,
   input  logic [15:0]        gap_scale,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SCORE_W-1:0] f_i,
   output logic [IDX_W-1:0]   best_j,
   output logic [IDX_W-1:0]   n_eval
);

   localparam int PROD_W = DEF_COORD_W + 16;

   s1_t s1_reg, s1_next;
   s2_t s2_reg, s2_next;
   s3_t s3_reg, s3_next;
   logic s1_valid_reg, s2_valid_reg, s3_valid_reg;

   score_t best_reg, best_next;
   idx_t   bj_reg, bj_next;
   idx_t   cnt_reg, cnt_next;
   logic   in_group_reg;

   logic   out_valid_reg;
   score_t f_i_reg;
   idx_t   best_j_reg;
   idx_t   n_eval_reg;

   logic stall, accept;

   assign stall    = out_valid_reg && !out_ready;
   assign in_ready = !rst && !stall;
   assign accept   = in_valid && in_ready;

   // ---------------- S1: differences and legality ----------------
   always_comb begin
      s1_next.dr    = coord_t'(riX) - coord_t'(riY);
      s1_next.dq    = coord_t'(qiX) - coord_t'(qiY);
      s1_next.f_j   = score_t'(f_j);
      s1_next.j_idx = idx_t'(j_idx);
      s1_next.w     = coord_t'(W);
      s1_next.last  = in_last;
      // Ordering checks come first so the wrapped differences are only
      // trusted when they are genuinely positive.
      s1_next.legal = pred_valid && (riX > riY) && (qiX > qiY) &&
                      (s1_next.dr <= coord_t'(MAX_DIST)) &&
                      (s1_next.dq <= coord_t'(MAX_DIST));
   end

   // ---------------- S2: overlap and gap pieces ----------------
   coord_t           g;
   logic [LOG_W-1:0] g_log2;
   logic             g_log2_valid;

   assign g = (s1_reg.dr >= s1_reg.dq) ? (s1_reg.dr - s1_reg.dq)
                                       : (s1_reg.dq - s1_reg.dr);

   ilog2 #(.W(DEF_COORD_W), .LOG_W(LOG_W)) u_ilog2 (
      .v     (g),
      .log2  (g_log2),
      .valid (g_log2_valid)
   );

   always_comb begin
      s2_next.a = s1_reg.dr;
      if (s1_reg.dq < s2_next.a) s2_next.a = s1_reg.dq;
      if (s1_reg.w  < s2_next.a) s2_next.a = s1_reg.w;
      s2_next.g_zero = !g_log2_valid;
      s2_next.mult   = score_t'((PROD_W'(g) * PROD_W'(gap_scale)) >> FRAC_BITS);
      s2_next.lg     = g_log2_valid ? LG_W'(g_log2 >> 1) : '0;
      s2_next.f_j    = s1_reg.f_j;
      s2_next.j_idx  = s1_reg.j_idx;
      s2_next.w      = s1_reg.w;
      s2_next.last   = s1_reg.last;
      s2_next.legal  = s1_reg.legal;
   end

   // ---------------- S3: pair score and saturating candidate ----------------
   score_t                 gap_cost, pair_score;
   logic signed [DEF_SCORE_W:0] cand_wide;

   always_comb begin
      gap_cost   = s2_reg.g_zero ? '0 : (s2_reg.mult + score_t'(s2_reg.lg));
      pair_score = score_t'(s2_reg.a) - gap_cost;
      cand_wide  = {s2_reg.f_j[DEF_SCORE_W-1], s2_reg.f_j} +
                   {pair_score[DEF_SCORE_W-1], pair_score};
      // Top two bits disagree exactly when the sum left the score_t range.
      if (cand_wide[DEF_SCORE_W] != cand_wide[DEF_SCORE_W-1]) begin
         s3_next.cand = cand_wide[DEF_SCORE_W] ? {1'b1, {(DEF_SCORE_W-1){1'b0}}}
                                               : {1'b0, {(DEF_SCORE_W-1){1'b1}}};
      end else begin
         s3_next.cand = cand_wide[DEF_SCORE_W-1:0];
      end
      s3_next.j_idx = s2_reg.j_idx;
      s3_next.w     = s2_reg.w;
      s3_next.last  = s2_reg.last;
      s3_next.legal = s2_reg.legal;
   end

   // ---------------- Running maximum ----------------
   always_comb begin
      // The first beat of a group starts from the "no predecessor" baseline.
      best_next = in_group_reg ? best_reg : score_t'(s3_reg.w);
      bj_next   = in_group_reg ? bj_reg   : NO_PRED;
      cnt_next  = in_group_reg ? cnt_reg  : '0;
      // Illegal beats and beats without a real predecessor leave the maximum untouched.
      if (s3_reg.legal) begin
         if (cnt_next != '1) cnt_next = cnt_next + 1'b1;
         if (s3_reg.cand > best_next) begin
            best_next = s3_reg.cand;
            bj_next   = s3_reg.j_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s3_valid_reg  <= 1'b0;
         in_group_reg  <= 1'b0;
         best_reg      <= '0;
         bj_reg        <= NO_PRED;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         f_i_reg       <= '0;
         best_j_reg    <= NO_PRED;
         n_eval_reg    <= '0;
      end else if (!stall) begin
         s1_valid_reg <= accept;
         if (accept) s1_reg <= s1_next;
         s2_valid_reg <= s1_valid_reg;
         s2_reg       <= s2_next;
         s3_valid_reg <= s2_valid_reg;
         s3_reg       <= s3_next;
         if (s3_valid_reg) begin
            best_reg     <= best_next;
            bj_reg       <= bj_next;
            cnt_reg      <= cnt_next;
            in_group_reg <= !s3_reg.last;
         end
         // Not stalled means any previous result was taken (or none was
         // shown), so out_valid simply reflects a completing group.
         out_valid_reg <= s3_valid_reg && s3_reg.last;
         if (s3_valid_reg && s3_reg.last) begin
            f_i_reg    <= best_next;
            best_j_reg <= bj_next;
            n_eval_reg <= cnt_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign f_i       = SCORE_W'(f_i_reg);
   assign best_j    = IDX_W'(best_j_reg);
   assign n_eval    = IDX_W'(n_eval_reg);

endmodule

// File: tb/tb_chain_score_pipe.sv
module tb_chain_score_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last, pred_valid;
   logic [31:0] riX, qiX, riY, qiY, W;
   logic [31:0] f_j;
   logic [15:0] j_idx, gap_scale;
   logic        out_valid, out_ready;
   logic [31:0] f_i;
   logic [15:0] best_j, n_eval;

   int total = 0;
   int bad   = 0;
   int n_pushed = 0;
   int n_popped = 0;

   typedef struct {
      logic [31:0] f;
      logic [15:0] bj;
      logic [15:0] n;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   chain_score_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .pred_valid(pred_valid),
      .riX(riX), .qiX(qiX), .riY(riY), .qiY(qiY),
      .f_j(f_j), .j_idx(j_idx), .W(W), .gap_scale(gap_scale),
      .out_valid(out_valid), .out_ready(out_ready),
      .f_i(f_i), .best_j(best_j), .n_eval(n_eval)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   task automatic expect_grp(input logic [31:0] f, input logic [15:0] bj, input logic [15:0] n);
      exp_t e;
      e.f = f; e.bj = bj; e.n = n;
      sb_q.push_back(e);
      n_pushed++;
   endtask

   // Presents one beat from a falling edge and returns just after the rising
   // edge on which it was accepted.
   task automatic send_beat(input logic pv, input logic [31:0] rix, input logic [31:0] riy,
                            input logic [31:0] qix, input logic [31:0] qiy,
                            input logic [31:0] fj, input logic [15:0] j,
                            input logic [31:0] w, input logic last);
      int tries = 0;
      @(negedge clk);
      pred_valid = pv; riX = rix; riY = riy; qiX = qix; qiY = qiy;
      f_j = fj; j_idx = j; W = w; in_last = last; in_valid = 1'b1;
      #1;
      while (!in_ready) begin
         tries++;
         if (tries > 200) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
            break;
         end
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      $display("beat j=%0d pv=%0b last=%0b accepted", j, pv, last);
      in_valid = 1'b0;
   endtask

   // Beat geometries (W=15, gap_scale=26):
   //   L    : dr=100 dq=90 -> A=15, g=10, mult=1, lg=1, score 13
   //   diag : dr=dq=50     -> score 15
   //   gap  : dr=100 dq=20 -> A=15, g=80, mult=8, lg=3, score 4
   task automatic beat_l(input logic [31:0] fj, input logic [15:0] j, input logic last);
      send_beat(1'b1, 32'd1000, 32'd900, 32'd500, 32'd410, fj, j, 32'd15, last);
   endtask
   task automatic beat_diag(input logic [31:0] fj, input logic [15:0] j, input logic last);
      send_beat(1'b1, 32'd1000, 32'd950, 32'd500, 32'd450, fj, j, 32'd15, last);
   endtask
   task automatic beat_gap(input logic [31:0] fj, input logic [15:0] j, input logic last);
      send_beat(1'b1, 32'd1000, 32'd900, 32'd500, 32'd480, fj, j, 32'd15, last);
   endtask

   task automatic check_reset_state();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_f_i", f_i, 32'd0);
      check("rst_best_j", 32'(best_j), 32'hFFFF);
      check("rst_n_eval", 32'(n_eval), 32'd0);
   endtask

   // Monitor: compares every presented result against the scoreboard and
   // checks that a stalled output holds still.
   logic        stall_prev = 1'b0;
   logic [31:0] f_prev;
   logic [15:0] bj_prev, n_prev;
   initial begin
      forever begin
         @(negedge clk); #2;
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (out_valid && !out_ready) begin
               check("stall_in_ready", 32'(in_ready), 32'd0);
               if (stall_prev) begin
                  check("stall_f_i", f_i, f_prev);
                  check("stall_best_j", 32'(best_j), 32'(bj_prev));
                  check("stall_n_eval", 32'(n_eval), 32'(n_prev));
               end
            end
            stall_prev = out_valid && !out_ready;
            f_prev = f_i; bj_prev = best_j; n_prev = n_eval;
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_output: f_i=%0d best_j=%0d n_eval=%0d want none",
                           $signed(f_i), best_j, n_eval);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  n_popped++;
                  $display("result f_i=%0d best_j=%0d n_eval=%0d (want %0d %0d %0d)",
                           $signed(f_i), best_j, n_eval, $signed(e.f), e.bj, e.n);
                  check("out_f_i", f_i, e.f);
                  check("out_best_j", 32'(best_j), 32'(e.bj));
                  check("out_n_eval", 32'(n_eval), 32'(e.n));
               end
            end
         end
      end
   end

   initial begin
      int waits;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; pred_valid = 1'b0;
      riX = '0; riY = '0; qiX = '0; qiY = '0; f_j = '0; j_idx = '0; W = '0;
      gap_scale = 16'd26; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_reset_state();
      rst = 1'b0;

      // Single legal pair plus latency: out_valid only after the third edge.
      expect_grp(32'd53, 16'd5, 16'd1);
      beat_l(32'd40, 16'd5, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("latency_early", 32'(out_valid), 32'd0);
      end
      @(negedge clk); #1;
      check("latency_on_time", 32'(out_valid), 32'd1);

      // Exact diagonal: cand equals W, so the baseline survives.
      expect_grp(32'd15, 16'hFFFF, 16'd1);
      beat_diag(32'd0, 16'd9, 1'b1);

      // Illegal beats (riX==riY, dr=6000) then the legal pair.
      expect_grp(32'd53, 16'd5, 16'd1);
      send_beat(1'b1, 32'd900, 32'd900, 32'd500, 32'd410, 32'd900, 16'd1, 32'd15, 1'b0);
      send_beat(1'b1, 32'd7000, 32'd1000, 32'd500, 32'd410, 32'd900, 16'd2, 32'd15, 1'b0);
      beat_l(32'd40, 16'd5, 1'b1);

      // Tie: the earlier predecessor wins.
      expect_grp(32'd53, 16'd3, 16'd2);
      beat_l(32'd40, 16'd3, 1'b0);
      beat_l(32'd40, 16'd7, 1'b1);

      // Group made of a single pred_valid=0 beat.
      expect_grp(32'd15, 16'hFFFF, 16'd0);
      send_beat(1'b0, 32'd1000, 32'd900, 32'd500, 32'd410, 32'd500, 16'd4, 32'd15, 1'b1);

      // Larger gap cost: score 4, f_j 40 -> 44.
      expect_grp(32'd44, 16'd8, 16'd1);
      beat_gap(32'd40, 16'd8, 1'b1);

      // Positive saturation of the candidate.
      expect_grp(32'h7FFF_FFFF, 16'd4, 16'd1);
      beat_l(32'h7FFF_FFFF, 16'd4, 1'b1);

      // Back-to-back groups with a 5-cycle back-pressure window.
      expect_grp(32'd53, 16'd5, 16'd1);
      expect_grp(32'd15, 16'hFFFF, 16'd1);
      expect_grp(32'd113, 16'd11, 16'd2);
      fork
         begin
            beat_l(32'd40, 16'd5, 1'b1);
            beat_diag(32'd0, 16'd9, 1'b1);
            beat_l(32'd100, 16'd11, 1'b0);
            beat_l(32'd40, 16'd2, 1'b1);
         end
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);

      // Reset in the middle of a group discards the partial beats.
      beat_l(32'd1000, 16'd9, 1'b0);
      beat_l(32'd1000, 16'd9, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      check_reset_state();
      rst = 1'b0;
      // pred_valid=0 beat, 53 (j1), 64 (j6), 25 (j2) -> best 64 from j6, 3 legal.
      expect_grp(32'd64, 16'd6, 16'd3);
      send_beat(1'b0, 32'd1000, 32'd900, 32'd500, 32'd410, 32'd5000, 16'd3, 32'd15, 1'b0);
      beat_l(32'd40, 16'd1, 1'b0);
      beat_gap(32'd60, 16'd6, 1'b0);
      beat_diag(32'd10, 16'd2, 1'b1);

      // Drain and make sure nothing is missing or duplicated.
      waits = 0;
      while (sb_q.size() != 0 && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      repeat (8) @(negedge clk);
      check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
      check("group_count", 32'(n_popped), 32'(n_pushed));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
